// File: rtl/icb_types.sv
// icb_types: shared ICB bus structs for the loader/storer masters.
package icb_types;
   localparam int ICB_AW = 32;
   localparam int ICB_DW = 32;
   localparam logic [1:0] ICB_SIZE_WORD = 2'b10;

   typedef struct packed {
      logic                  valid;
      logic [ICB_AW-1:0]     addr;
      logic                  read;
      logic [ICB_DW-1:0]     wdata;
      logic [ICB_DW/8-1:0]   wmask;
      logic [1:0]            size;
   } icb_cmd_m_t;

   typedef struct packed {
      logic ready;
   } icb_cmd_s_t;

   typedef struct packed {
      logic              rsp_valid;
      logic [ICB_DW-1:0] rsp_rdata;
      logic              rsp_err;
   } icb_rsp_s_t;

   typedef struct packed {
      logic rsp_ready;
   } icb_rsp_m_t;
endpackage

// File: rtl/result_storer_pkg.sv
// result_storer_pkg: sequencing states of the result storer.
package result_storer_pkg;
   typedef enum logic [2:0] {IDLE, ACCEPT, ISSUE, DRAIN, DONE} state_t;
endpackage

// File: rtl/result_word_packer.sv
// result_word_packer: selects one little-endian bus word of a buffered row,
// masking and zeroing lanes at or beyond cols.
module result_word_packer #(
   parameter int DATA_WIDTH = 8,
   parameter int SIZE       = 16,
   parameter int BUS_WIDTH  = 32
) (
   input  logic signed [SIZE-1:0][DATA_WIDTH-1:0]              row_i,
   input  logic [$clog2(SIZE/(BUS_WIDTH/DATA_WIDTH))-1:0]      word_idx_i,
   input  logic [$clog2(SIZE+1)-1:0]                           cols_i,
   output logic [BUS_WIDTH-1:0]                                wdata_o,
   output logic [BUS_WIDTH/DATA_WIDTH-1:0]                     wmask_o
);
   localparam int EPW = BUS_WIDTH / DATA_WIDTH;
   localparam int EW  = $clog2(SIZE);
   localparam int CW  = $clog2(SIZE + 1);

   for (genvar b = 0; b < EPW; b++) begin : g_lane
      logic [EW-1:0] e;
      assign e = EW'(word_idx_i) * EW'(EPW) + EW'(b);
      assign wmask_o[b] = CW'(e) < cols_i;
      assign wdata_o[b*DATA_WIDTH +: DATA_WIDTH] = wmask_o[b] ? row_i[e] : '0;
   end
endmodule

// File: rtl/result_storer.sv
// result_storer: ICB write master packing int8 output rows into words and
// walking a row-strided region per tile, one row in flight at a time.
module result_storer
   import icb_types::*;
   import result_storer_pkg::*;
#(
   parameter int DATA_WIDTH      = 8,
   parameter int SIZE            = 16,
   parameter int BUS_WIDTH       = 32,
   parameter int REG_WIDTH       = 32,
   parameter int MAX_OUTSTANDING = 4
) (
   input  logic                                   clk,
   input  logic                                   rst_n,
   input  logic                                   init_cfg,
   input  logic [REG_WIDTH-1:0]                   rows,
   input  logic [REG_WIDTH-1:0]                   cols,
   input  logic [REG_WIDTH-1:0]                   tile_count,
   input  logic [REG_WIDTH-1:0]                   dst_base,
   input  logic [REG_WIDTH-1:0]                   dst_row_stride_b,
   input  logic [REG_WIDTH-1:0]                   dst_tile_stride_b,
   input  logic                                   row_valid,
   output logic                                   row_ready,
   input  logic signed [SIZE-1:0][DATA_WIDTH-1:0] row_data,
   output icb_cmd_m_t                             icb_cmd_m,
   input  icb_cmd_s_t                             icb_cmd_s,
   input  icb_rsp_s_t                             icb_rsp_s,
   output icb_rsp_m_t                             icb_rsp_m,
   output logic                                   tile_store_done,
   output logic                                   all_done,
   output logic                                   store_err
);
   localparam int EPW = BUS_WIDTH / DATA_WIDTH;
   localparam int CW  = $clog2(SIZE + 1);
   localparam int WW  = $clog2(SIZE / EPW);
   localparam int OW  = $clog2(MAX_OUTSTANDING + 1);

   state_t                                 state_q, state_d;
   logic [REG_WIDTH-1:0]                   rows_q, rows_d, tiles_q, tiles_d;
   logic [REG_WIDTH-1:0]                   rstride_q, rstride_d, tstride_q, tstride_d;
   logic [REG_WIDTH-1:0]                   tile_base_q, tile_base_d, row_addr_q, row_addr_d;
   logic [REG_WIDTH-1:0]                   row_idx_q, row_idx_d, tile_idx_q, tile_idx_d;
   logic [CW-1:0]                          cols_q, cols_d, nwords;
   logic [WW-1:0]                          word_idx_q, word_idx_d;
   logic [OW-1:0]                          outst_q, outst_d;
   logic signed [SIZE-1:0][DATA_WIDTH-1:0] row_buf_q, row_buf_d;
   logic                                   err_q, err_d, tdone_q, tdone_d;
   logic                                   cmd_valid, cmd_fire, rsp_fire;
   logic                                   last_word, last_row, last_tile;
   logic [BUS_WIDTH-1:0]                   wdata;
   logic [EPW-1:0]                         wmask;
   logic                                   unused_rdata;

   result_word_packer #(
      .DATA_WIDTH(DATA_WIDTH),
      .SIZE      (SIZE),
      .BUS_WIDTH (BUS_WIDTH)
   ) u_packer (
      .row_i     (row_buf_q),
      .word_idx_i(word_idx_q),
      .cols_i    (cols_q),
      .wdata_o   (wdata),
      .wmask_o   (wmask)
   );

   assign nwords       = (cols_q + CW'(EPW - 1)) >> $clog2(EPW);
   assign last_word    = CW'(word_idx_q) + CW'(1) == nwords;
   // >= rather than < rows-1 so rows == 0 finishes the tile instead of wrapping
   assign last_row     = row_idx_q + REG_WIDTH'(1) >= rows_q;
   assign last_tile    = tile_idx_q + REG_WIDTH'(1) == tiles_q;
   assign cmd_valid    = state_q == ISSUE && outst_q != OW'(MAX_OUTSTANDING);
   assign cmd_fire     = cmd_valid && icb_cmd_s.ready;
   assign rsp_fire     = icb_rsp_m.rsp_ready && icb_rsp_s.rsp_valid;
   assign unused_rdata = ^icb_rsp_s.rsp_rdata;

   always_comb begin
      icb_cmd_m       = '0;
      icb_cmd_m.valid = cmd_valid;
      icb_cmd_m.addr  = row_addr_q + (REG_WIDTH'(word_idx_q) << 2);
      icb_cmd_m.read  = 1'b0;
      icb_cmd_m.wdata = wdata;
      icb_cmd_m.wmask = wmask;
      icb_cmd_m.size  = ICB_SIZE_WORD;
   end

   assign icb_rsp_m.rsp_ready = state_q == ISSUE || state_q == DRAIN;
   assign row_ready           = state_q == ACCEPT && rows_q != '0;
   assign tile_store_done     = tdone_q;
   assign all_done            = state_q == DONE;
   assign store_err           = err_q;

   always_comb begin
      state_d     = state_q;
      rows_d      = rows_q;
      cols_d      = cols_q;
      tiles_d     = tiles_q;
      rstride_d   = rstride_q;
      tstride_d   = tstride_q;
      tile_base_d = tile_base_q;
      row_addr_d  = row_addr_q;
      row_idx_d   = row_idx_q;
      tile_idx_d  = tile_idx_q;
      word_idx_d  = word_idx_q;
      row_buf_d   = row_buf_q;
      tdone_d     = 1'b0;
      outst_d     = outst_q + OW'(cmd_fire) - OW'(rsp_fire);
      err_d       = err_q | (rsp_fire & icb_rsp_s.rsp_err);
      case (state_q)
         IDLE, DONE: if (init_cfg) begin
            rows_d      = rows;
            cols_d      = cols > REG_WIDTH'(SIZE) ? CW'(SIZE) : cols[CW-1:0];
            tiles_d     = tile_count;
            rstride_d   = dst_row_stride_b;
            tstride_d   = dst_tile_stride_b;
            tile_base_d = dst_base;
            row_addr_d  = dst_base;
            row_idx_d   = '0;
            tile_idx_d  = '0;
            word_idx_d  = '0;
            err_d       = 1'b0;
            state_d     = tile_count == '0 ? DONE : ACCEPT;
         end
         ACCEPT: if (rows_q == '0) begin
            state_d = DRAIN;
         end else if (row_valid) begin
            row_buf_d = row_data;
            state_d   = cols_q == '0 ? DRAIN : ISSUE;
         end
         ISSUE: if (cmd_fire) begin
            word_idx_d = last_word ? '0 : word_idx_q + WW'(1);
            state_d    = last_word ? DRAIN : ISSUE;
         end
         DRAIN: if (outst_q == '0) begin
            if (!last_row) begin
               row_idx_d  = row_idx_q + REG_WIDTH'(1);
               row_addr_d = row_addr_q + rstride_q;
               state_d    = ACCEPT;
            end else begin
               tdone_d     = 1'b1;
               row_idx_d   = '0;
               tile_base_d = tile_base_q + tstride_q;
               row_addr_d  = tile_base_q + tstride_q;
               tile_idx_d  = tile_idx_q + REG_WIDTH'(1);
               state_d     = last_tile ? DONE : (rows_q == '0 ? DRAIN : ACCEPT);
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= IDLE;
         rows_q      <= '0;
         cols_q      <= '0;
         tiles_q     <= '0;
         rstride_q   <= '0;
         tstride_q   <= '0;
         tile_base_q <= '0;
         row_addr_q  <= '0;
         row_idx_q   <= '0;
         tile_idx_q  <= '0;
         word_idx_q  <= '0;
         outst_q     <= '0;
         row_buf_q   <= '0;
         err_q       <= 1'b0;
         tdone_q     <= 1'b0;
      end else begin
         state_q     <= state_d;
         rows_q      <= rows_d;
         cols_q      <= cols_d;
         tiles_q     <= tiles_d;
         rstride_q   <= rstride_d;
         tstride_q   <= tstride_d;
         tile_base_q <= tile_base_d;
         row_addr_q  <= row_addr_d;
         row_idx_q   <= row_idx_d;
         tile_idx_q  <= tile_idx_d;
         word_idx_q  <= word_idx_d;
         outst_q     <= outst_d;
         row_buf_q   <= row_buf_d;
         err_q       <= err_d;
         tdone_q     <= tdone_d;
      end
   end
endmodule

// File: tb/tb_result_storer.sv
// tb_result_storer: directed vectors against result_storer with a small ICB
// slave (stall, delayed responses, error injection) and a row feeder.
module tb_result_storer;
   import icb_types::*;
   import result_storer_pkg::*;

   localparam int SIZE = 16;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   logic                           init_cfg;
   logic [31:0]                    rows, cols, tile_count, dst_base, dst_row_stride_b, dst_tile_stride_b;
   logic                           row_valid, row_ready;
   logic signed [SIZE-1:0][7:0]    row_data;
   icb_cmd_m_t                     icb_cmd_m;
   icb_cmd_s_t                     icb_cmd_s;
   icb_rsp_s_t                     icb_rsp_s;
   icb_rsp_m_t                     icb_rsp_m;
   logic                           tile_store_done, all_done, store_err;

   result_storer dut (
      .clk              (clk),
      .rst_n            (rst_n),
      .init_cfg         (init_cfg),
      .rows             (rows),
      .cols             (cols),
      .tile_count       (tile_count),
      .dst_base         (dst_base),
      .dst_row_stride_b (dst_row_stride_b),
      .dst_tile_stride_b(dst_tile_stride_b),
      .row_valid        (row_valid),
      .row_ready        (row_ready),
      .row_data         (row_data),
      .icb_cmd_m        (icb_cmd_m),
      .icb_cmd_s        (icb_cmd_s),
      .icb_rsp_s        (icb_rsp_s),
      .icb_rsp_m        (icb_rsp_m),
      .tile_store_done  (tile_store_done),
      .all_done         (all_done),
      .store_err        (store_err)
   );

   typedef struct {
      int          rows, cols, tiles;
      logic [31:0] base, rs, ts;
      int          stall, dly, err_idx;
      int          n_wr, n_pulse, n_pop;
      logic        err;
      logic [31:0] addr0, data0, addr_l, data_l;
      logic [3:0]  mask_l;
   } vec_t;

   int checks = 0, errors = 0;
   int cyc = 0, stall_left = 0, rsp_dly = 0, err_idx = -1, rsp_cnt = 0, out_tb = 0;
   int pops = 0, pulses = 0, feed_t = 0, feed_r = 0, cfg_rows = 0, cfg_tiles = 0;
   bit feed_en = 0, held = 0;
   int due_q[$];
   logic [31:0] w_addr[$], w_data[$];
   logic [3:0]  w_mask[$];
   logic [31:0] h_addr, h_data;
   logic [3:0]  h_mask;

   task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   function automatic logic [SIZE-1:0][7:0] mkrow(int t, int r);
      logic [SIZE-1:0][7:0] v;
      for (int k = 0; k < SIZE; k++) v[k] = 8'(t * 32 + r * 16 + k);
      return v;
   endfunction

   // Observe at negedge (handshakes complete on the next posedge), drive at posedge+1
   initial begin
      icb_cmd_s = '0;
      icb_rsp_s = '0;
      row_valid = 1'b0;
      row_data  = '0;
      forever begin
         @(negedge clk);
         cyc++;
         if (!rst_n) begin
            out_tb = 0;
            due_q.delete();
            held = 0;
         end else begin
            if (held) begin
               chk("cmd_valid_held", 32'(icb_cmd_m.valid), 1);
               chk("cmd_addr_stable", icb_cmd_m.addr, h_addr);
               chk("cmd_wdata_stable", icb_cmd_m.wdata, h_data);
               chk("cmd_wmask_stable", 32'(icb_cmd_m.wmask), 32'(h_mask));
            end
            if (out_tb != 0) chk("row_ready_low_while_outstanding", 32'(row_ready), 0);
            if (tile_store_done) pulses++;
            if (row_valid && row_ready) begin
               pops++;
               feed_r++;
               if (feed_r == cfg_rows) begin
                  feed_r = 0;
                  feed_t++;
               end
            end
            if (icb_rsp_s.rsp_valid && icb_rsp_m.rsp_ready) begin
               void'(due_q.pop_front());
               out_tb--;
               rsp_cnt++;
            end
            if (icb_cmd_m.valid && icb_cmd_s.ready) begin
               w_addr.push_back(icb_cmd_m.addr);
               w_data.push_back(icb_cmd_m.wdata);
               w_mask.push_back(icb_cmd_m.wmask);
               due_q.push_back(cyc + rsp_dly);
               out_tb++;
               chk("outstanding_le_4", 32'(out_tb <= 4), 1);
               chk("cmd_read", 32'(icb_cmd_m.read), 0);
               chk("cmd_size", 32'(icb_cmd_m.size), 2);
            end
            held   = icb_cmd_m.valid && !icb_cmd_s.ready;
            h_addr = icb_cmd_m.addr;
            h_data = icb_cmd_m.wdata;
            h_mask = icb_cmd_m.wmask;
            if (icb_cmd_m.valid && stall_left > 0) stall_left--;
         end
         @(posedge clk);
         #1;
         icb_cmd_s.ready     = stall_left == 0;
         icb_rsp_s.rsp_valid = due_q.size() > 0 && due_q[0] <= cyc;
         icb_rsp_s.rsp_err   = icb_rsp_s.rsp_valid && rsp_cnt == err_idx;
         icb_rsp_s.rsp_rdata = 32'hDEAD_BEEF;
         row_valid           = feed_en && feed_t < cfg_tiles;
         row_data            = mkrow(feed_t, feed_r);
      end
   end

   task automatic start_job(int r, int c, int t, logic [31:0] b, logic [31:0] rs, logic [31:0] ts,
                            int st, int dl, int ei);
      @(posedge clk);
      #1;
      stall_left = st;
      rsp_dly    = dl;
      err_idx    = ei;
      rsp_cnt    = 0;
      pops       = 0;
      pulses     = 0;
      w_addr.delete();
      w_data.delete();
      w_mask.delete();
      feed_t     = 0;
      feed_r     = 0;
      cfg_rows   = r;
      cfg_tiles  = t;
      feed_en    = 1;
      rows = r; cols = c; tile_count = t;
      dst_base = b; dst_row_stride_b = rs; dst_tile_stride_b = ts;
      init_cfg = 1'b1;
      @(posedge clk);
      #1;
      init_cfg = 1'b0;
   endtask

   task automatic wait_done();
      int i = 0;
      while (!all_done && i < 3000) begin
         @(negedge clk);
         i++;
      end
      chk("all_done_reached", 32'(all_done), 1);
   endtask

   task automatic wait_valid();
      int i = 0;
      while (!icb_cmd_m.valid && i < 200) begin
         @(negedge clk);
         i++;
      end
      chk("cmd_valid_seen", 32'(icb_cmd_m.valid), 1);
   endtask

   task automatic run_vec(vec_t v);
      int bad = 0, idx = 0;
      int cc = v.cols > SIZE ? SIZE : v.cols;
      int nw = (cc + 3) / 4;
      logic [31:0] ea, ed;
      logic [3:0]  em;
      start_job(v.rows, v.cols, v.tiles, v.base, v.rs, v.ts, v.stall, v.dly, v.err_idx);
      wait_done();
      repeat (2) @(negedge clk);
      chk("all_done_held", 32'(all_done), 1);
      chk("write_count", w_addr.size(), v.n_wr);
      chk("tile_pulses", pulses, v.n_pulse);
      chk("rows_popped", pops, v.n_pop);
      chk("store_err", 32'(store_err), 32'(v.err));
      if (v.n_wr > 0) begin
         chk("addr_first", w_addr[0], v.addr0);
         chk("wdata_first", w_data[0], v.data0);
         chk("addr_last", w_addr[w_addr.size()-1], v.addr_l);
         chk("wdata_last", w_data[w_data.size()-1], v.data_l);
         chk("wmask_last", 32'(w_mask[w_mask.size()-1]), 32'(v.mask_l));
      end
      for (int t = 0; t < v.tiles; t++)
         for (int r = 0; r < v.rows; r++)
            for (int w = 0; w < nw; w++) begin
               ea = v.base + 32'(t) * v.ts + 32'(r) * v.rs + 32'(4 * w);
               for (int b = 0; b < 4; b++) begin
                  em[b] = w * 4 + b < cc;
                  ed[b*8 +: 8] = em[b] ? 8'(t * 32 + r * 16 + w * 4 + b) : 8'h00;
               end
               if (idx >= w_addr.size() || w_addr[idx] !== ea || w_data[idx] !== ed || w_mask[idx] !== em)
                  bad++;
               idx++;
            end
      chk("write_stream_model", bad, 0);
   endtask

   vec_t vt[9];

   initial begin
      #500000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1, "watchdog");
   end

   initial begin
      vt[0] = '{2, 16, 1, 'h1000, 'h40, 'h0,   0, 0, -1, 8, 1, 2, 0, 'h1000, 'h03020100, 'h104C, 'h1F1E1D1C, 'hF};
      vt[1] = '{2,  6, 1, 'h2000, 'h40, 'h0,   0, 0, -1, 4, 1, 2, 0, 'h2000, 'h03020100, 'h2044, 'h00001514, 'h3};
      vt[2] = '{2, 16, 1, 'h3000, 'h40, 'h0,   5, 8, -1, 8, 1, 2, 0, 'h3000, 'h03020100, 'h304C, 'h1F1E1D1C, 'hF};
      vt[3] = '{1,  4, 3, 'h4000, 'h40, 'h400, 0, 0, -1, 3, 3, 3, 0, 'h4000, 'h03020100, 'h4800, 'h43424140, 'hF};
      vt[4] = '{2,  8, 1, 'h5000, 'h20, 'h0,   0, 2,  1, 4, 1, 2, 1, 'h5000, 'h03020100, 'h5024, 'h17161514, 'hF};
      vt[5] = '{1, 20, 1, 'h6000, 'h40, 'h0,   0, 0, -1, 4, 1, 1, 0, 'h6000, 'h03020100, 'h600C, 'h0F0E0D0C, 'hF};
      vt[6] = '{2,  0, 2, 'h6800, 'h40, 'h100, 0, 0, -1, 0, 2, 4, 0, 0, 0, 0, 0, 0};
      vt[7] = '{0,  4, 2, 'h6C00, 'h40, 'h100, 0, 0, -1, 0, 2, 0, 0, 0, 0, 0, 0, 0};
      vt[8] = '{2,  4, 0, 'h7000, 'h40, 'h100, 0, 0, -1, 0, 0, 0, 0, 0, 0, 0, 0, 0};
      init_cfg = 0; rows = 0; cols = 0; tile_count = 0;
      dst_base = 0; dst_row_stride_b = 0; dst_tile_stride_b = 0;
      repeat (3) @(negedge clk);
      chk("rst_cmd_valid", 32'(icb_cmd_m.valid), 0);
      chk("rst_row_ready", 32'(row_ready), 0);
      chk("rst_rsp_ready", 32'(icb_rsp_m.rsp_ready), 0);
      chk("rst_tile_done", 32'(tile_store_done), 0);
      chk("rst_all_done", 32'(all_done), 0);
      chk("rst_store_err", 32'(store_err), 0);
      chk("rst_state", 32'(dut.state_q), 32'(IDLE));
      @(posedge clk);
      #1 rst_n = 1'b1;
      // tile_count == 0 from IDLE: all_done visible the cycle after the transition
      @(posedge clk);
      #1 init_cfg = 1'b1;
      @(negedge clk);
      chk("zero_tiles_before", 32'(all_done), 0);
      @(posedge clk);
      #1 init_cfg = 1'b0;
      @(negedge clk);
      chk("zero_tiles_done", 32'(all_done), 1);
      chk("zero_tiles_no_pulse", 32'(tile_store_done), 0);
      for (int i = 0; i < 9; i++) run_vec(vt[i]);
      // init_cfg while stalled in ISSUE must not disturb the job
      start_job(2, 16, 1, 'h7000, 'h40, 'h0, 1000, 0, -1);
      wait_valid();
      @(posedge clk);
      #1;
      dst_base = 'h9000; tile_count = 0; init_cfg = 1'b1;
      @(posedge clk);
      #1 init_cfg = 1'b0;
      @(negedge clk);
      chk("init_ignored_state", 32'(dut.state_q), 32'(ISSUE));
      chk("init_ignored_addr", icb_cmd_m.addr, 'h7000);
      stall_left = 0;
      wait_done();
      chk("init_ignored_count", w_addr.size(), 8);
      chk("init_ignored_addr0", w_addr[0], 'h7000);
      chk("init_ignored_addr7", w_addr[7], 'h704C);
      // asynchronous reset while a command is pending
      start_job(2, 16, 1, 'h7800, 'h40, 'h0, 1000, 0, -1);
      wait_valid();
      @(posedge clk);
      #1 rst_n = 1'b0;
      #1;
      chk("midrst_cmd_valid", 32'(icb_cmd_m.valid), 0);
      chk("midrst_state", 32'(dut.state_q), 32'(IDLE));
      chk("midrst_row_ready", 32'(row_ready), 0);
      chk("midrst_rsp_ready", 32'(icb_rsp_m.rsp_ready), 0);
      feed_en = 0;
      repeat (2) @(posedge clk);
      #1 rst_n = 1'b1;
      stall_left = 0;
      run_vec(vt[3]);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
